// File: rtl/wb_queue_if.sv
// wb_queue_if: pipeline-side bundle for wb_queue (request, register-file write and lookup signals).
interface wb_queue_if;
  logic        in_valid;
  logic [4:0]  in_dest;
  logic [31:0] in_data;
  logic        in_ready;
  logic        flush;
  logic        wr_hold;
  logic        reg_write_en;
  logic [4:0]  write_dest;
  logic [31:0] write_data;
  logic [4:0]  look_reg1;
  logic [4:0]  look_reg2;
  logic        look_hit1;
  logic        look_hit2;
  logic [31:0] look_data1;
  logic [31:0] look_data2;
  logic [2:0]  count;
  modport master (
    output in_valid, in_dest, in_data, flush, wr_hold, look_reg1, look_reg2,
    input  in_ready, reg_write_en, write_dest, write_data, look_hit1, look_hit2,
           look_data1, look_data2, count
  );
  modport slave (
    input  in_valid, in_dest, in_data, flush, wr_hold, look_reg1, look_reg2,
    output in_ready, reg_write_en, write_dest, write_data, look_hit1, look_hit2,
           look_data1, look_data2, count
  );
endinterface

// File: rtl/wb_queue.sv
// wb_queue: 4-entry in-order writeback queue with decode lookup.
// Defining WBQ_BYPASS_EN lets a request reach the register file in its own cycle when the queue is empty.
module wb_queue #(parameter int DEPTH = 4) (
  input logic       clk,
  input logic       reset,
  wb_queue_if.slave q
);
  logic [4:0]  dest_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [1:0]  head, tail, idx;
  logic [2:0]  cnt, cnt_v;
  logic        byp, acc, deq;
  // reset masks every combinational output, even before the reset edge lands
  assign cnt_v = reset ? 3'd0 : cnt;
`ifdef WBQ_BYPASS_EN
  assign byp = !reset && cnt == 3'd0 && q.in_valid && !q.wr_hold && !q.flush && q.in_dest != 5'd0;
`else
  assign byp = 1'b0;
`endif
  assign q.count        = cnt_v;
  assign q.in_ready     = cnt_v < 3'(DEPTH);
  assign q.reg_write_en = !reset && !q.wr_hold && (cnt != 3'd0 || byp);
  assign q.write_dest   = !q.reg_write_en ? 5'd0 : byp ? q.in_dest : dest_q[head];
  assign q.write_data   = !q.reg_write_en ? 32'd0 : byp ? q.in_data : data_q[head];
  assign deq = q.reg_write_en && !byp;
  assign acc = q.in_valid && q.in_ready && !q.flush && q.in_dest != 5'd0 && !byp;
  // walk oldest to youngest so the youngest match wins
  always_comb begin
    q.look_hit1  = 1'b0;
    q.look_hit2  = 1'b0;
    q.look_data1 = 32'd0;
    q.look_data2 = 32'd0;
    idx = 2'd0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + 2'(i);
      if (3'(i) < cnt_v && q.look_reg1 != 5'd0 && dest_q[idx] == q.look_reg1) begin
        q.look_hit1  = 1'b1;
        q.look_data1 = data_q[idx];
      end
      if (3'(i) < cnt_v && q.look_reg2 != 5'd0 && dest_q[idx] == q.look_reg2) begin
        q.look_hit2  = 1'b1;
        q.look_data2 = data_q[idx];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset || q.flush) begin
      head <= 2'd0;
      tail <= 2'd0;
      cnt  <= 3'd0;
    end else begin
      if (acc) begin
        dest_q[tail] <= q.in_dest;
        data_q[tail] <= q.in_data;
        tail <= tail + 2'd1;
      end
      if (deq) head <= head + 2'd1;
      cnt <= cnt + 3'(acc) - 3'(deq);
    end
  end
endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered writeback entries; only the value 4 is supported.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  writeback request from the pipeline.
REQ-005 in_dest  input  5  destination register number.
REQ-006 in_data  input  32  writeback data.
REQ-007 in_ready  output  1  queue can accept a request this cycle.
REQ-008 flush  input  1  synchronous discard of all queued entries.
REQ-009 wr_hold  input  1  register-file write port unavailable this cycle.
REQ-010 reg_write_en  output  1  write strobe to the register file.
REQ-011 write_dest  output  5  register-file write address.
REQ-012 write_data  output  32  register-file write data.
REQ-013 look_reg1, look_reg2  input  5 each  decode-stage source registers.
REQ-014 look_hit1, look_hit2  output  1 each  a queued entry targets the looked-up register.
REQ-015 look_data1, look_data2  output  32 each  data of the youngest matching entry; 0 when there is no hit.
REQ-016 count  output  3  number of occupied entries, 0..4.

Function
REQ-017 Storage SHALL be a circular FIFO with 2-bit head and tail pointers that wrap from 3 to 0.
REQ-018 in_ready SHALL equal (count < 4); a dequeue in the same cycle SHALL NOT make a full queue ready.
REQ-019 A request is accepted on a clock edge when in_valid && in_ready && !flush.
REQ-020 An accepted request with in_dest == 0 SHALL be dropped without enqueueing or writing.
REQ-021 reg_write_en SHALL be combinational: (count != 0) && !wr_hold, with write_dest and write_data taken from the head entry.
REQ-022 The head SHALL dequeue on a clock edge when reg_write_en is 1; at most one write per cycle.
REQ-023 When no write is pending, write_dest and write_data SHALL be 0.
REQ-024 Enqueue and dequeue in the same cycle SHALL leave count unchanged and advance both pointers.
REQ-025 Entries SHALL drain in strict arrival order, including repeated writes to the same register.
REQ-026 A lookup SHALL hit the youngest valid entry whose dest matches; look_reg == 0 SHALL never hit.
REQ-027 A lookup SHALL NOT consider the current-cycle input; a lookup on the head entry being written this cycle SHALL still hit.
REQ-028 flush SHALL take priority: on that edge count becomes 0, both pointers reset to 0, and any same-cycle input is discarded; reg_write_en is not masked in the flush cycle.
REQ-029 With wr_hold held high, the queue SHALL retain its contents indefinitely and keep accepting requests until full.

Reset
REQ-030 A clock edge with reset high SHALL clear count and both pointers, and reset SHALL override flush and all inputs.
REQ-031 While reset is high and after reset, outputs SHALL be: reg_write_en 0, in_ready 1, look_hit 0, look_data 0, write_dest 0, write_data 0, count 0.
REQ-032 Entry data SHALL NOT require a reset value.
REQ-033 Reset asserted mid-drain SHALL discard all pending entries; no write SHALL be issued after the reset edge.

Configuration
REQ-034 Macro WBQ_BYPASS_EN: when defined, and count == 0 && in_valid && !wr_hold && !flush && in_dest != 0, reg_write_en SHALL be 1 in the same cycle, write_dest/write_data SHALL come from the input, and the request SHALL NOT be enqueued.
REQ-035 Without WBQ_BYPASS_EN, every write SHALL have a minimum latency of one cycle from acceptance.

Verification
REQ-036 Enqueue (dest 5, 0xA5A5A5A5) into the empty queue, wr_hold 0 -> next cycle reg_write_en 1, write_dest 5, write_data 0xA5A5A5A5; count returns to 0. With WBQ_BYPASS_EN -> write occurs in the acceptance cycle and count stays 0.
REQ-037 wr_hold 1; enqueue dest 1,2,3,4,5 on consecutive cycles -> count 4, in_ready 0, the fifth request is not accepted; release hold -> writes to 1,2,3,4 in order.
REQ-038 Queue holds dest 7 = 0x11 then dest 7 = 0x22; look_reg1 7 -> look_hit1 1, look_data1 0x22; look_reg2 0 -> look_hit2 0, look_data2 0.
REQ-039 Enqueue dest 0, data 0xFFFFFFFF -> no write, count stays 0.
REQ-040 Queue with 3 entries; assert flush together with in_valid -> next cycle count 0, no write issued; repeat with reset instead of flush -> same result and in_ready 1.
REQ-041 Hold wr_hold high until full, then pulse wr_hold low for one cycle while presenting a new request -> one write issued, request not accepted that cycle, accepted the following cycle; pointers wrap and order is preserved.
